// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_pkg: shared helpers and types for regfile_mport.   Rev 1.0     |
// +------------------------------------------------------------------------+
package regfile_pkg;

  localparam int MAX_R = 4;

  // Status of one read port as seen by a consumer (used by benches/monitors).
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_VALID = 2'd1,
    RD_BUSY  = 2'd2
  } rd_status_e;

  // Address width for n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_onehot.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | code_onehot: binary code to N-bit one-hot, all-zero when code >= N.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module code_onehot
  import regfile_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = addr_w(N)
) (
  input  logic [AW-1:0] code,
  output logic [N-1:0]  onehot
);

  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign onehot[i] = (code == AW'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_mport.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_mport: R registered read ports, 1 write port, pending scoreboard|
// | Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass. Rev 1.0  |
// +------------------------------------------------------------------------+
module regfile_mport
  import regfile_pkg::*;
#(
  parameter int N        = 32,
  parameter int Bits     = 64,
  parameter int R        = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [R-1:0]      rd_en,
  input  logic [R*AW-1:0]   rd_code,
  output logic [R*Bits-1:0] rd_data,
  output logic [R-1:0]      rd_valid,
  output logic [R-1:0]      rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_code,
  input  logic [Bits-1:0]   wr_data,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_code,
  output logic              any_pending
);

  // Register 0 is excluded from writes and pending marks when hardwired.
  localparam logic [N-1:0] KEEP_MASK =
    (ZERO_REG != 0) ? {{(N-1){1'b1}}, 1'b0} : {N{1'b1}};

  logic [Bits-1:0]   mem [N];
  logic [N-1:0]      pending;
  logic [N-1:0]      pending_nxt;
  logic [N-1:0]      wr_oh;
  logic [N-1:0]      wr_sel;
  logic [N-1:0]      pend_oh;
  logic [N-1:0]      pend_sel;
  logic [R*N-1:0]    rd_oh;
  logic [R*Bits-1:0] mux_data;
  logic [R-1:0]      mux_busy;
  logic [N-1:0]      port_oh;
  logic [Bits-1:0]   port_d;

  code_onehot #(.N(N), .AW(AW)) u_wr_dec (
    .code   (wr_code),
    .onehot (wr_oh)
  );

  generate
    for (genvar i = 0; i < R; i++) begin : g_rd_dec
      code_onehot #(.N(N), .AW(AW)) u_rd_dec (
        .code   (rd_code[i*AW +: AW]),
        .onehot (rd_oh[i*N +: N])
      );
    end
  endgenerate

  always_comb begin
    pend_oh = '0;
    for (int j = 0; j < N; j++) pend_oh[j] = (pend_code == AW'(j));
  end

  assign wr_sel      = wr_oh & {N{wr_en}} & KEEP_MASK;
  assign pend_sel    = pend_oh & {N{pend_set}} & KEEP_MASK;
  // A fresh mark beats a same-cycle writeback: a new producer is in flight.
  assign pending_nxt = (pending & ~wr_sel) | pend_sel;

  always_comb begin
    mux_data = '0;
    mux_busy = '0;
    port_oh  = '0;
    port_d   = '0;
    for (int p = 0; p < R; p++) begin
      port_oh = rd_oh[p*N +: N];
      port_d  = '0;
      for (int j = 0; j < N; j++) port_d = port_d | (mem[j] & {Bits{port_oh[j]}});
      mux_data[p*Bits +: Bits] = port_d;
      mux_busy[p]              = |(port_oh & pending);
`ifdef REGFILE_BYPASS_EN
      if (|(port_oh & wr_sel)) begin
        mux_data[p*Bits +: Bits] = wr_data;
        mux_busy[p]              = |(port_oh & pend_sel);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) mem[j] <= '0;
      pending     <= '0;
      any_pending <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= '0;
      rd_busy     <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (wr_sel[j]) mem[j] <= wr_data;
      end
      pending     <= pending_nxt;
      any_pending <= |pending_nxt;
      rd_valid    <= rd_en;
      // Idle ports keep their last data/busy so consumers can re-sample.
      for (int p = 0; p < R; p++) begin
        if (rd_en[p]) begin
          rd_data[p*Bits +: Bits] <= mux_data[p*Bits +: Bits];
          rd_busy[p]              <= mux_busy[p];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mport.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_mport: scoreboard bench for regfile_mport (N=20, R=2).      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_regfile_mport;
  import regfile_pkg::*;

  localparam int N  = 20;
  localparam int B  = 64;
  localparam int R  = 2;
  localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] COLL_EXP = 64'hA5;
`else
  localparam logic [63:0] COLL_EXP = 64'h11;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic        b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [R-1:0]    rd_en = '0;
  logic [R*AW-1:0] rd_code = '0;
  logic [R*B-1:0]  rd_data;
  logic [R-1:0]    rd_valid;
  logic [R-1:0]    rd_busy;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_code = '0;
  logic [B-1:0]    wr_data = '0;
  logic            pend_set = 1'b0;
  logic [AW-1:0]   pend_code = '0;
  logic            any_pending;

  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  exp_t sbq [R][$];
  exp_t exp_q [R];
  exp_t mon_e;
  rd_status_e st_act, st_exp;

  regfile_mport #(.N(N), .Bits(B), .R(R), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .rd_code     (rd_code),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_code     (wr_code),
    .wr_data     (wr_data),
    .pend_set    (pend_set),
    .pend_code   (pend_code),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic rd(input int p, input logic [AW-1:0] code, input logic [63:0] d, input logic b);
    rd_en[p]            = 1'b1;
    rd_code[p*AW +: AW] = code;
    exp_q[p]            = '{d: d, b: b};
  endtask

  task automatic wr(input logic [AW-1:0] code, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_code = code;
    wr_data = d;
  endtask

  task automatic pend(input logic [AW-1:0] code);
    pend_set  = 1'b1;
    pend_code = code;
  endtask

  // Expectations are queued on the edge that samples the read request.
  task automatic tick();
    @(posedge clk);
    for (int p = 0; p < R; p++) if (rd_en[p]) sbq[p].push_back(exp_q[p]);
    #1;
    rd_en    = '0;
    wr_en    = 1'b0;
    pend_set = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < R; p++) begin
        if (rd_valid[p]) begin
          if (sbq[p].size() == 0) begin
            tot_cnt++;
            $display("FAIL unexpected_valid port%0d: got 1 expected 0 (t=%0t)", p, $time);
          end else begin
            mon_e  = sbq[p].pop_front();
            st_act = rd_busy[p] ? RD_BUSY : RD_VALID;
            st_exp = mon_e.b ? RD_BUSY : RD_VALID;
            check($sformatf("rd_data%0d", p), rd_data[p*B +: B], mon_e.d);
            check($sformatf("rd_status%0d", p), 64'(st_act), 64'(st_exp));
          end
        end else if (sbq[p].size() != 0) begin
          tot_cnt++;
          $display("FAIL missing_valid port%0d: got 0 expected 1 (t=%0t)", p, $time);
          void'(sbq[p].pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(rd_valid), 64'h0);
    check("rst_data",  rd_data[63:0] | rd_data[127:64], 64'h0);
    check("rst_busy",  64'(rd_busy), 64'h0);
    check("rst_anyp",  64'(any_pending), 64'h0);
    rst_n = 1'b1;
    tick();

    // basic write then read
    wr(5, 64'hDEAD_BEEF);                 tick();
    rd(0, 5, 64'hDEAD_BEEF, 1'b0);
    rd(1, 5, 64'hDEAD_BEEF, 1'b0);        tick();

    // hardwired zero register
    wr(0, 64'h1);                         tick();
    rd(0, 0, 64'h0, 1'b0);
    rd(1, 0, 64'h0, 1'b0);                tick();
    pend(0);                              tick();
    check("zero_pend_anyp", 64'(any_pending), 64'h0);
    rd(0, 0, 64'h0, 1'b0);                tick();

    // pending scoreboard on reg 7
    pend(7);                              tick();
    check("pend7_anyp", 64'(any_pending), 64'h1);
    rd(0, 7, 64'h0, 1'b1);
    rd(1, 7, 64'h0, 1'b1);                tick();
    wr(7, 64'h42);                        tick();
    check("wr7_anyp", 64'(any_pending), 64'h0);
    rd(0, 7, 64'h42, 1'b0);
    rd(1, 7, 64'h42, 1'b0);               tick();

    // read/write collision on reg 3
    wr(3, 64'h11);                        tick();
    wr(3, 64'hA5);
    rd(0, 3, COLL_EXP, 1'b0);
    rd(1, 3, COLL_EXP, 1'b0);             tick();
    rd(1, 3, 64'hA5, 1'b0);               tick();

    // same-edge set and clear on reg 9: set wins
    pend(9);
    wr(9, 64'h77);                        tick();
    check("setclr9_anyp", 64'(any_pending), 64'h1);
    rd(0, 9, 64'h77, 1'b1);               tick();

    // out-of-range codes
    rd(0, 25, 64'h0, 1'b0);
    rd(1, 20, 64'h0, 1'b0);               tick();
    wr(25, 64'hFFFF_FFFF_FFFF_FFFF);      tick();
    wr(20, 64'hFFFF_FFFF_FFFF_FFFF);      tick();
    rd(0, 5, 64'hDEAD_BEEF, 1'b0);
    rd(1, 19, 64'h0, 1'b0);               tick();

    // idle port holds data/busy, no valid
    tick();
    check("hold_valid", 64'(rd_valid), 64'h0);
    check("hold_data0", rd_data[63:0], 64'hDEAD_BEEF);
    check("hold_data1", rd_data[127:64], 64'h0);

    // reset asserted while a read result is being presented
    rd(0, 9, 64'h77, 1'b1);               tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(rd_valid), 64'h0);
    check("midrst_data",  rd_data[63:0] | rd_data[127:64], 64'h0);
    check("midrst_busy",  64'(rd_busy), 64'h0);
    check("midrst_anyp",  64'(any_pending), 64'h0);
    for (int p = 0; p < R; p++) sbq[p].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    rd(0, 5, 64'h0, 1'b0);
    rd(1, 9, 64'h0, 1'b0);                tick();
    tick();

    check("sbq0_empty", 64'(sbq[0].size()), 64'h0);
    check("sbq1_empty", 64'(sbq[1].size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
